// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles every handshake and RAM-side signal of mem_port_arbiter.
//   slave  : the arbiter's view (requests and ram_dout in; acks, data and
//            RAM strobes out).
//   master : the requester/RAM side view (mirror of slave).
//   Fetch port : if_req, if_addr -> if_ack, if_rdata, if_err
//   Data port  : d_req, d_we, d_size, d_signed, d_addr, d_wdata
//                -> d_ack, d_rdata, d_err
//   RAM side   : ram_enable, ram_rw, ram_addr, ram_din, ram_size <- ram_dout
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if;
    logic        if_req;
    logic [8:0]  if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_err;

    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_signed;
    logic [8:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        ram_enable;
    logic        ram_rw;
    logic [8:0]  ram_addr;
    logic [31:0] ram_din;
    logic [1:0]  ram_size;
    logic [31:0] ram_dout;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_size, d_signed, d_addr, d_wdata,
        input  ram_dout,
        output if_ack, if_rdata, if_err,
        output d_ack, d_rdata, d_err,
        output ram_enable, ram_rw, ram_addr, ram_din, ram_size
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_size, d_signed, d_addr, d_wdata,
        output ram_dout,
        input  if_ack, if_rdata, if_err,
        input  d_ack, d_rdata, d_err,
        input  ram_enable, ram_rw, ram_addr, ram_din, ram_size
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported, byte-addressed, big-endian 512-byte RAM between
//   the instruction-fetch port and the load/store port. Each grant becomes a
//   single RAM access: IDLE (arbitrate + latch) -> ACCESS (one-cycle strobe)
//   -> RESP (ack with extended read data). A request failing its alignment
//   check skips ACCESS and pulses err from RESP instead.
//
// Ports
//   clk    : clock, all state on the rising edge
//   reset  : synchronous, active-high reset
//   io_bus : mem_port_arbiter_if.slave (fetch port, data port, RAM side)
//
// Parameters
//   STARVE_MAX : consecutive data grants allowed while a fetch waits
//
// Configuration macro
//   MEM_ARB_ALIGN_CHECK_EN : defined   -> misaligned/reserved-size requests
//                                         return if_err/d_err, no access
//                            undefined -> addresses forced aligned, size 11
//                                         treated as word, err tied to 0
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int STARVE_MAX = 2
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  io_bus
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [SW-1:0] r_starve;
    logic          w_grant_i;
    logic          w_grant_d;

    logic [8:0]    w_raw_addr;
    logic [1:0]    w_raw_size;
    logic          w_raw_we;
    logic          w_raw_signed;
    logic [31:0]   w_raw_wdata;

    logic [8:0]    w_sel_addr;
    logic [1:0]    w_sel_size;
    logic          w_sel_err;

    logic          r_port_i;
    logic          r_we;
    logic [1:0]    r_size;
    logic          r_signed;
    logic [8:0]    r_addr;
    logic [31:0]   r_wdata;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic          r_err;
`endif

`ifdef MEM_ARB_ALIGN_CHECK_EN
    // 1 when the address does not meet the natural alignment of the size,
    // or the size code is the reserved 11.
    function automatic logic f_misaligned(input logic [8:0] addr, input logic [1:0] size);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr[0];
            2'b10:   bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction
`else
    // Clears the low address bits that the access size cannot use.
    function automatic logic [8:0] f_force_align(input logic [8:0] addr, input logic [1:0] size);
        logic [8:0] res;
        case (size)
            2'b00:   res = addr;
            2'b01:   res = {addr[8:1], 1'b0};
            default: res = {addr[8:2], 2'b00};
        endcase
        return res;
    endfunction
`endif

    // Sign- or zero-extends right-justified RAM data to 32 bits.
    function automatic logic [31:0] f_extend(input logic [31:0] raw, input logic [1:0] size,
                                             input logic sgn);
        logic [31:0] res;
        case (size)
            2'b00:   res = {{24{sgn & raw[7]}}, raw[7:0]};
            2'b01:   res = {{16{sgn & raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // Arbitration: data first, fetch when alone or when the starvation limit is hit.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (r_state == ST_IDLE) begin
            if (io_bus.if_req && (!io_bus.d_req || (r_starve >= STARVE_LIM))) begin
                w_grant_i = 1'b1;
            end else if (io_bus.d_req) begin
                w_grant_d = 1'b1;
            end else begin
                w_grant_i = 1'b0;
            end
        end else begin
            w_grant_d = 1'b0;
        end
    end

    // Select the winning port's request fields; fetches are always word reads.
    always_comb begin
        if (w_grant_i) begin
            w_raw_addr   = io_bus.if_addr;
            w_raw_size   = 2'b10;
            w_raw_we     = 1'b0;
            w_raw_signed = 1'b0;
            w_raw_wdata  = 32'h0000_0000;
        end else begin
            w_raw_addr   = io_bus.d_addr;
            w_raw_size   = io_bus.d_size;
            w_raw_we     = io_bus.d_we;
            w_raw_signed = io_bus.d_signed;
            w_raw_wdata  = io_bus.d_we ? io_bus.d_wdata : 32'h0000_0000;
        end
    end

    // Alignment handling: either flag the request or silently align it.
    always_comb begin
`ifdef MEM_ARB_ALIGN_CHECK_EN
        w_sel_err  = f_misaligned(w_raw_addr, w_raw_size);
        w_sel_addr = w_raw_addr;
        w_sel_size = w_raw_size;
`else
        w_sel_err  = 1'b0;
        w_sel_addr = f_force_align(w_raw_addr, w_raw_size);
        w_sel_size = (w_raw_size == 2'b11) ? 2'b10 : w_raw_size;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; a failed check goes straight to RESP to pulse err.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_i || w_grant_d) begin
                    w_state_nxt = w_sel_err ? ST_RESP : ST_ACCESS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch the granted request so later requester changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_port_i <= 1'b0;
            r_we     <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_addr   <= 9'h000;
            r_wdata  <= 32'h0000_0000;
`ifdef MEM_ARB_ALIGN_CHECK_EN
            r_err    <= 1'b0;
`endif
        end else if (w_grant_i || w_grant_d) begin
            r_port_i <= w_grant_i;
            r_we     <= w_raw_we;
            r_size   <= w_sel_size;
            r_signed <= w_raw_signed;
            r_addr   <= w_sel_addr;
            r_wdata  <= w_raw_wdata;
`ifdef MEM_ARB_ALIGN_CHECK_EN
            r_err    <= w_sel_err;
`endif
        end else begin
            r_port_i <= r_port_i;
        end
    end

    // Starvation counter: saturating count of data grants made while a fetch waits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve <= {SW{1'b0}};
        end else if (w_grant_i) begin
            r_starve <= {SW{1'b0}};
        end else if (w_grant_d && io_bus.if_req && (r_starve < STARVE_LIM)) begin
            r_starve <= r_starve + SW'(1);
        end else begin
            r_starve <= r_starve;
        end
    end

    // FSM outputs: RAM strobe in ACCESS, ack/err with read data in RESP.
    // Read data is taken straight from ram_dout, which is valid in RESP.
    always_comb begin
        io_bus.ram_enable = 1'b0;
        io_bus.ram_rw     = 1'b0;
        io_bus.ram_addr   = 9'h000;
        io_bus.ram_din    = 32'h0000_0000;
        io_bus.ram_size   = 2'b00;
        io_bus.if_ack     = 1'b0;
        io_bus.if_rdata   = 32'h0000_0000;
        io_bus.if_err     = 1'b0;
        io_bus.d_ack      = 1'b0;
        io_bus.d_rdata    = 32'h0000_0000;
        io_bus.d_err      = 1'b0;
        case (r_state)
            ST_ACCESS: begin
                io_bus.ram_enable = 1'b1;
                io_bus.ram_rw     = ~r_we;
                io_bus.ram_addr   = r_addr;
                io_bus.ram_din    = r_wdata;
                io_bus.ram_size   = r_size;
            end
            ST_RESP: begin
`ifdef MEM_ARB_ALIGN_CHECK_EN
                if (r_err) begin
                    io_bus.if_err = r_port_i;
                    io_bus.d_err  = ~r_port_i;
                end else
`endif
                if (r_port_i) begin
                    io_bus.if_ack   = 1'b1;
                    io_bus.if_rdata = io_bus.ram_dout;
                end else begin
                    io_bus.d_ack   = 1'b1;
                    io_bus.d_rdata = r_we ? 32'h0000_0000
                                          : f_extend(io_bus.ram_dout, r_size, r_signed);
                end
            end
            default: begin
                io_bus.ram_enable = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed self-checking bench for mem_port_arbiter with a big-endian
//   512-byte RAM model. Inputs change and outputs are sampled on the falling
//   edge; a request driven at falling edge k is granted at the next rising
//   edge, so ram_enable is seen at k+1 and ack/err at k+2 (err at k+1).
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    logic [7:0] mem [0:511];
    logic [8:0] ra0, ra1, ra2, ra3;

    mem_port_arbiter_if u_if ();

    mem_port_arbiter #(.STARVE_MAX(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (u_if.slave)
    );

    always #5 clk = ~clk;

    assign ra0 = u_if.ram_addr;
    assign ra1 = ra0 + 9'd1;
    assign ra2 = ra0 + 9'd2;
    assign ra3 = ra0 + 9'd3;

    // Big-endian RAM model: read data right-justified, valid the cycle after the strobe.
    always @(posedge clk) begin
        if (u_if.ram_enable === 1'b1) begin
            if (u_if.ram_rw) begin
                case (u_if.ram_size)
                    2'b00:   u_if.ram_dout <= {24'h0, mem[ra0]};
                    2'b01:   u_if.ram_dout <= {16'h0, mem[ra0], mem[ra1]};
                    default: u_if.ram_dout <= {mem[ra0], mem[ra1], mem[ra2], mem[ra3]};
                endcase
            end else begin
                case (u_if.ram_size)
                    2'b00: mem[ra0] = u_if.ram_din[7:0];
                    2'b01: begin
                        mem[ra0] = u_if.ram_din[15:8];
                        mem[ra1] = u_if.ram_din[7:0];
                    end
                    default: begin
                        mem[ra0] = u_if.ram_din[31:24];
                        mem[ra1] = u_if.ram_din[23:16];
                        mem[ra2] = u_if.ram_din[15:8];
                        mem[ra3] = u_if.ram_din[7:0];
                    end
                endcase
            end
        end
    end

    task automatic drive_d(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [8:0] addr, input logic [31:0] wdata);
        u_if.d_we     = we;
        u_if.d_size   = size;
        u_if.d_signed = sgn;
        u_if.d_addr   = addr;
        u_if.d_wdata  = wdata;
        u_if.d_req    = 1'b1;
    endtask

    task automatic test_reset();
        logic [112:0] outs;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        outs = {u_if.if_ack, u_if.if_rdata, u_if.if_err, u_if.d_ack, u_if.d_rdata, u_if.d_err,
                u_if.ram_enable, u_if.ram_rw, u_if.ram_addr, u_if.ram_din, u_if.ram_size};
        tests++;
        if (outs !== '0) begin fails++; $display("FAIL reset_outs: got %h expected 0", outs); end
        drive_d(1'b0, 2'b10, 1'b0, 9'h020, 32'h0);
        @(negedge clk);
        tests++;
        if (u_if.ram_enable !== 1'b1) begin fails++; $display("FAIL reset_access: ram_enable %b expected 1", u_if.ram_enable); end
        reset = 1'b1;
        u_if.d_req = 1'b0;
        @(negedge clk);
        tests++;
        if ({u_if.d_ack, u_if.ram_enable} !== 2'b00) begin fails++; $display("FAIL reset_abandon: ack/en %b expected 00", {u_if.d_ack, u_if.ram_enable}); end
        reset = 1'b0;
        @(negedge clk);
        outs = {u_if.if_ack, u_if.if_rdata, u_if.if_err, u_if.d_ack, u_if.d_rdata, u_if.d_err,
                u_if.ram_enable, u_if.ram_rw, u_if.ram_addr, u_if.ram_din, u_if.ram_size};
        tests++;
        if (outs !== '0) begin fails++; $display("FAIL reset_release: got %h expected 0", outs); end
        @(negedge clk);
        tests++;
        if (u_if.d_ack !== 1'b0) begin fails++; $display("FAIL reset_no_late_ack: d_ack %b expected 0", u_if.d_ack); end
    endtask

    task automatic test_byte_load();
        logic [31:0] exp_data [2];
        logic        sgn_val  [2];
        exp_data[0] = 32'hFFFF_FF80; sgn_val[0] = 1'b1;
        exp_data[1] = 32'h0000_0080; sgn_val[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive_d(1'b0, 2'b00, sgn_val[i], 9'h005, 32'h0);
            @(negedge clk);
            tests++;
            if ({u_if.ram_enable, u_if.ram_rw, u_if.ram_size, u_if.ram_addr, u_if.d_ack} !== {1'b1, 1'b1, 2'b00, 9'h005, 1'b0}) begin
                fails++; $display("FAIL byte_load_access[%0d]: en/rw/size/addr/ack %b %b %b %h %b", i,
                                  u_if.ram_enable, u_if.ram_rw, u_if.ram_size, u_if.ram_addr, u_if.d_ack);
            end
            // Fields changed after grant must be ignored.
            u_if.d_signed = ~sgn_val[i];
            u_if.d_size   = 2'b10;
            @(negedge clk);
            tests++;
            if ({u_if.d_ack, u_if.d_rdata, u_if.ram_enable} !== {1'b1, exp_data[i], 1'b0}) begin
                fails++; $display("FAIL byte_load_ack[%0d]: ack %b rdata %h expected 1 %h", i, u_if.d_ack, u_if.d_rdata, exp_data[i]);
            end
            u_if.d_req = 1'b0;
            @(negedge clk);
            tests++;
            if (u_if.d_ack !== 1'b0) begin fails++; $display("FAIL byte_load_pulse[%0d]: d_ack %b expected 0", i, u_if.d_ack); end
        end
    endtask

    task automatic test_hw_store();
        @(negedge clk);
        drive_d(1'b1, 2'b01, 1'b0, 9'h010, 32'h0000_BEEF);
        @(negedge clk);
        tests++;
        if ({u_if.ram_enable, u_if.ram_rw, u_if.ram_size, u_if.ram_addr, u_if.ram_din} !== {1'b1, 1'b0, 2'b01, 9'h010, 32'h0000_BEEF}) begin
            fails++; $display("FAIL hw_store_access: en/rw/size/addr/din %b %b %b %h %h",
                              u_if.ram_enable, u_if.ram_rw, u_if.ram_size, u_if.ram_addr, u_if.ram_din);
        end
        @(negedge clk);
        tests++;
        if ({u_if.d_ack, u_if.d_rdata} !== {1'b1, 32'h0}) begin
            fails++; $display("FAIL hw_store_ack: ack %b rdata %h expected 1 00000000", u_if.d_ack, u_if.d_rdata);
        end
        u_if.d_req = 1'b0;
        tests++;
        if ({mem[9'h010], mem[9'h011]} !== 16'hBEEF) begin
            fails++; $display("FAIL hw_store_mem: got %h expected beef", {mem[9'h010], mem[9'h011]});
        end
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        drive_d(1'b0, 2'b10, 1'b0, 9'h002, 32'h0);
        @(negedge clk);
`ifdef MEM_ARB_ALIGN_CHECK_EN
        tests++;
        if ({u_if.d_err, u_if.d_ack, u_if.ram_enable} !== 3'b100) begin
            fails++; $display("FAIL misaligned_err: err/ack/en %b expected 100", {u_if.d_err, u_if.d_ack, u_if.ram_enable});
        end
        u_if.d_req = 1'b0;
        @(negedge clk);
        tests++;
        if ({u_if.d_err, u_if.d_ack, u_if.ram_enable} !== 3'b000) begin
            fails++; $display("FAIL misaligned_after: err/ack/en %b expected 000", {u_if.d_err, u_if.d_ack, u_if.ram_enable});
        end
        drive_d(1'b0, 2'b11, 1'b0, 9'h000, 32'h0);
        @(negedge clk);
        tests++;
        if ({u_if.d_err, u_if.ram_enable} !== 2'b10) begin
            fails++; $display("FAIL reserved_size_err: err/en %b expected 10", {u_if.d_err, u_if.ram_enable});
        end
        u_if.d_req   = 1'b0;
        @(negedge clk);
        u_if.if_addr = 9'h021;
        u_if.if_req  = 1'b1;
        @(negedge clk);
        tests++;
        if ({u_if.if_err, u_if.if_ack, u_if.d_err, u_if.ram_enable} !== 4'b1000) begin
            fails++; $display("FAIL fetch_misaligned_err: ierr/iack/derr/en %b expected 1000",
                              {u_if.if_err, u_if.if_ack, u_if.d_err, u_if.ram_enable});
        end
        u_if.if_req = 1'b0;
        @(negedge clk);
`else
        tests++;
        if ({u_if.ram_enable, u_if.ram_addr, u_if.ram_size, u_if.d_err} !== {1'b1, 9'h000, 2'b10, 1'b0}) begin
            fails++; $display("FAIL misaligned_forced: en/addr/size/err %b %h %b %b expected 1 000 10 0",
                              u_if.ram_enable, u_if.ram_addr, u_if.ram_size, u_if.d_err);
        end
        @(negedge clk);
        tests++;
        if ({u_if.d_ack, u_if.d_rdata, u_if.d_err} !== {1'b1, 32'hCAFE_F00D, 1'b0}) begin
            fails++; $display("FAIL misaligned_forced_ack: ack %b rdata %h expected 1 cafef00d", u_if.d_ack, u_if.d_rdata);
        end
        u_if.d_req = 1'b0;
        @(negedge clk);
        drive_d(1'b0, 2'b11, 1'b0, 9'h003, 32'h0);
        @(negedge clk);
        tests++;
        if ({u_if.ram_enable, u_if.ram_addr, u_if.ram_size} !== {1'b1, 9'h000, 2'b10}) begin
            fails++; $display("FAIL reserved_size_word: en/addr/size %b %h %b expected 1 000 10",
                              u_if.ram_enable, u_if.ram_addr, u_if.ram_size);
        end
        @(negedge clk);
        u_if.d_req = 1'b0;
        @(negedge clk);
`endif
    endtask

    task automatic test_fetch_halfword();
        @(negedge clk);
        u_if.if_addr = 9'h020;
        u_if.if_req  = 1'b1;
        @(negedge clk);
        tests++;
        if ({u_if.ram_enable, u_if.ram_rw, u_if.ram_size, u_if.ram_addr, u_if.if_ack} !== {1'b1, 1'b1, 2'b10, 9'h020, 1'b0}) begin
            fails++; $display("FAIL fetch_access: en/rw/size/addr/ack %b %b %b %h %b",
                              u_if.ram_enable, u_if.ram_rw, u_if.ram_size, u_if.ram_addr, u_if.if_ack);
        end
        @(negedge clk);
        tests++;
        if ({u_if.if_ack, u_if.if_rdata, u_if.d_ack} !== {1'b1, 32'h1234_5678, 1'b0}) begin
            fails++; $display("FAIL fetch_ack: ack %b rdata %h expected 1 12345678", u_if.if_ack, u_if.if_rdata);
        end
        u_if.if_req = 1'b0;
        @(negedge clk);
        drive_d(1'b1, 2'b01, 1'b0, 9'h022, 32'h0000_8001);
        repeat (2) @(negedge clk);
        u_if.d_req = 1'b0;
        @(negedge clk);
        drive_d(1'b0, 2'b01, 1'b1, 9'h022, 32'h0);
        @(negedge clk);
        tests++;
        if ({u_if.ram_addr, u_if.ram_size} !== {9'h022, 2'b01}) begin
            fails++; $display("FAIL hw_load_access: addr %h size %b expected 022 01", u_if.ram_addr, u_if.ram_size);
        end
        @(negedge clk);
        tests++;
        if ({u_if.d_ack, u_if.d_rdata} !== {1'b1, 32'hFFFF_8001}) begin
            fails++; $display("FAIL hw_load_signed: ack %b rdata %h expected 1 ffff8001", u_if.d_ack, u_if.d_rdata);
        end
        u_if.d_req = 1'b0;
        @(negedge clk);
        drive_d(1'b0, 2'b01, 1'b0, 9'h022, 32'h0);
        repeat (2) @(negedge clk);
        tests++;
        if ({u_if.d_ack, u_if.d_rdata} !== {1'b1, 32'h0000_8001}) begin
            fails++; $display("FAIL hw_load_unsigned: ack %b rdata %h expected 1 00008001", u_if.d_ack, u_if.d_rdata);
        end
        u_if.d_req = 1'b0;
        @(negedge clk);
        u_if.if_req = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({u_if.if_ack, u_if.if_rdata} !== {1'b1, 32'h1234_8001}) begin
            fails++; $display("FAIL refetch_big_endian: ack %b rdata %h expected 1 12348001", u_if.if_ack, u_if.if_rdata);
        end
        u_if.if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_starvation();
        logic [1:0] exp_acks;
        @(negedge clk);
        u_if.if_addr = 9'h020;
        u_if.if_req  = 1'b1;
        drive_d(1'b0, 2'b00, 1'b1, 9'h005, 32'h0);
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            exp_acks = {(i == 8) || (i == 17), (i == 2) || (i == 5) || (i == 11) || (i == 14)};
            tests++;
            if ({u_if.if_ack, u_if.d_ack} !== exp_acks) begin
                fails++; $display("FAIL starvation_cycle%0d: if_ack/d_ack %b expected %b", i, {u_if.if_ack, u_if.d_ack}, exp_acks);
            end
        end
        u_if.if_req = 1'b0;
        u_if.d_req  = 1'b0;
        @(negedge clk);
        tests++;
        if ({u_if.ram_enable, u_if.if_ack, u_if.d_ack} !== 3'b000) begin
            fails++; $display("FAIL starvation_drain: en/iack/dack %b expected 000", {u_if.ram_enable, u_if.if_ack, u_if.d_ack});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 512; a++) mem[a] = 8'h00;
        mem[0] = 8'hCA; mem[1] = 8'hFE; mem[2] = 8'hF0; mem[3] = 8'h0D;
        mem[5] = 8'h80;
        mem[32] = 8'h12; mem[33] = 8'h34; mem[34] = 8'h56; mem[35] = 8'h78;
        reset         = 1'b1;
        u_if.if_req   = 1'b0;
        u_if.if_addr  = 9'h000;
        u_if.d_req    = 1'b0;
        u_if.d_we     = 1'b0;
        u_if.d_size   = 2'b00;
        u_if.d_signed = 1'b0;
        u_if.d_addr   = 9'h000;
        u_if.d_wdata  = 32'h0;

        test_reset();
        test_byte_load();
        test_hw_store();
        test_misaligned();
        test_fetch_halfword();
        test_starvation();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the single-ported, byte-addressed, big-endian 512-byte data RAM between the instruction-fetch port and the load/store port. Each accepted request becomes exactly one RAM access: the block checks alignment, drives the RAM enable, read/write, address and size lines, then returns load data with sign or zero extension. It sits between the pipeline's fetch and memory stages and the RAM instance.

## Interface
- `STARVE_MAX`, default 2: maximum consecutive data-port grants while an instruction request waits.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: synchronous reset, active high.
- `if_req` in 1: instruction fetch request; held until `if_ack`.
- `if_addr` in 9: fetch byte address.
- `if_ack` out 1: one-cycle pulse; `if_rdata` is valid in the same cycle.
- `if_rdata` out 32: fetched word.
- `if_err` out 1: one-cycle pulse on a misaligned fetch, instead of `if_ack`.
- `d_req` in 1: load/store request; held until `d_ack` or `d_err`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_size` in 2: 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- `d_signed` in 1: sign-extend load data when 1.
- `d_addr` in 9: load/store byte address.
- `d_wdata` in 32: store data, right-justified.
- `d_ack` out 1: one-cycle completion pulse.
- `d_rdata` out 32: extended load data, valid with `d_ack`; 0 on stores.
- `d_err` out 1: one-cycle pulse on a misaligned address or reserved size.
- `ram_enable` out 1: RAM access strobe.
- `ram_rw` out 1: 1 = read, 0 = write.
- `ram_addr` out 9: RAM byte address.
- `ram_din` out 32: RAM write data.
- `ram_size` out 2: access size, same encoding as `d_size`.
- `ram_dout` in 32: right-justified RAM read data, valid in the cycle after `ram_enable`.

## Operation
- The FSM has three states: IDLE, ACCESS and RESP.
- **IDLE:** if any request is present, arbitrate, latch the winner's fields into registers, and go to ACCESS. If the winner fails its check, skip the access, pulse `err` next cycle, and return to IDLE.
- **ACCESS:** `ram_enable` = 1 for exactly one cycle, with the latched address, size, rw and data. Go to RESP.
- **RESP:** capture `ram_dout`, drive the extended data with `ack` for one cycle, and return to IDLE.
- **Arbitration:**
  - The data port has priority.
  - A saturating counter `starve` increments on each data grant while `if_req` = 1.
  - When `starve` = `STARVE_MAX` and `if_req` = 1, the instruction port wins and `starve` clears. Any instruction grant clears `starve`.
- **Fetch:** always a word read (`ram_size` = 10, `ram_rw` = 1).
- **Alignment:** the halfword check is `addr[0]` = 0; the word check is `addr[1:0]` = 00. Size 11 is an error.
- **Extension:**
  - A signed byte load replicates bit 7 into [31:8]; a signed halfword load replicates bit 15 into [31:16].
  - Unsigned loads zero-fill. Word loads pass through unchanged.
- **Stores:** `d_rdata` = 0 on store completions.
- **Ordering:** requests not granted stay pending; requesters must hold their inputs stable until `ack` or `err`. Any request-field change during that time is ignored because the fields were latched at grant.
- **Reset values:** all outputs 0, state IDLE, `starve` 0. A reset during ACCESS or RESP abandons the access and produces no `ack`. A RAM write already strobed is not undone.

## Timing
- A request seen in IDLE at cycle N gives `ram_enable` at N+1 and `ack` at N+2. The next grant can be decided at N+3.
- Throughput: one access per 3 cycles.
- A misaligned request seen at cycle N gives `err` at N+1 with no `ram_enable`. IDLE is re-entered at N+2.
- Simultaneous `if_req` and `d_req` in IDLE: data wins unless the starvation rule fires.
- `ack` and `err` are never asserted together, and never to both ports in the same cycle.

## Configuration
- `MEM_ARB_ALIGN_CHECK_EN` defined:
  - Alignment and reserved-size checks are active, and `if_err`/`d_err` pulse as described.
- `MEM_ARB_ALIGN_CHECK_EN` undefined:
  - No checks are made and `if_err`/`d_err` are tied to 0.
  - Addresses are forced aligned: low bit cleared for halfword, low two bits cleared for word and fetch.
  - Size 11 is treated as word.

## Test plan
- **Reset:** assert `reset` during ACCESS of a load → no `d_ack`; all outputs 0 the cycle after reset is released.
- **Signed byte load:** `d_req`, `d_size` = 00, `d_signed` = 1, addr 0x005, RAM byte 0x80 → `ram_enable` at N+1, `d_ack` at N+2, `d_rdata` = 0xFFFFFF80. Repeat with `d_signed` = 0 → 0x00000080.
- **Halfword store:** `d_we` = 1, `d_size` = 01, addr 0x010, `d_wdata` = 0x0000BEEF → `ram_rw` = 0, `ram_size` = 01, `ram_din` = 0x0000BEEF, `d_ack` with `d_rdata` = 0.
- **Misaligned word, macro defined:** word load, addr 0x002 → `d_err` at N+1, no `ram_enable`. Macro undefined → `ram_addr` = 0x000 and `d_ack` at N+2.
- **Starvation:** `if_req` and `d_req` both held continuously → grant order D, D, I, D, D, I; `if_ack` every 9 cycles.
- **Sign-extended halfword:** load word-aligned fetch 0x12345678 at 0x020, then signed halfword load at 0x022 with RAM value 0x8001 → `if_rdata` = 0x12345678, `d_rdata` = 0xFFFF8001.
